control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer. Fetch runs in T0-T2 and the opcode-driven execute runs in T3-T7.
// The sequencer enters HALT on the halt opcode, or on a Stop request at an instruction boundary.
module control_sequencer (
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Stop,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   output logic [31:0] ctrl,
   output logic [4:0]  ALU_op,
   output logic        Run,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_RST  = 4'b0000,
      S_T0   = 4'b0001,
      S_T1   = 4'b0010,
      S_T2   = 4'b0011,
      S_T3   = 4'b0100,
      S_T4   = 4'b0101,
      S_T5   = 4'b0110,
      S_T6   = 4'b0111,
      S_T7   = 4'b1000,
      S_HALT = 4'b1111
   } state_t;

   typedef enum logic [3:0] {
      C_LDW    = 4'd0,
      C_LDWI   = 4'd1,
      C_STW    = 4'd2,
      C_ALU    = 4'd3,
      C_IMM    = 4'd4,
      C_MULDIV = 4'd5,
      C_NEGNOT = 4'd6,
      C_BR     = 4'd7,
      C_JR     = 4'd8,
      C_JAL    = 4'd9,
      C_IN     = 4'd10,
      C_OUT    = 4'd11,
      C_MFHI   = 4'd12,
      C_MFLO   = 4'd13,
      C_NOP    = 4'd14,
      C_HALT   = 4'd15
   } class_t;

   localparam logic [31:0] M_PC_OUT    = 32'h0000_0001;
   localparam logic [31:0] M_ZLOW_OUT  = 32'h0000_0002;
   localparam logic [31:0] M_ZHIGH_OUT = 32'h0000_0004;
   localparam logic [31:0] M_MDR_OUT   = 32'h0000_0008;
   localparam logic [31:0] M_HI_OUT    = 32'h0000_0010;
   localparam logic [31:0] M_LO_OUT    = 32'h0000_0020;
   localparam logic [31:0] M_INP_OUT   = 32'h0000_0040;
   localparam logic [31:0] M_C_OUT     = 32'h0000_0080;
   localparam logic [31:0] M_BA_OUT    = 32'h0000_0100;
   localparam logic [31:0] M_R_OUT     = 32'h0000_0200;
   localparam logic [31:0] M_PC_EN     = 32'h0000_0400;
   localparam logic [31:0] M_IR_EN     = 32'h0000_0800;
   localparam logic [31:0] M_MAR_EN    = 32'h0000_1000;
   localparam logic [31:0] M_MDR_EN    = 32'h0000_2000;
   localparam logic [31:0] M_MDR_READ  = 32'h0000_4000;
   localparam logic [31:0] M_RAM_WR    = 32'h0000_8000;
   localparam logic [31:0] M_Y_EN      = 32'h0001_0000;
   localparam logic [31:0] M_ZLOW_IN   = 32'h0002_0000;
   localparam logic [31:0] M_ZHIGH_IN  = 32'h0004_0000;
   localparam logic [31:0] M_HI_EN     = 32'h0008_0000;
   localparam logic [31:0] M_LO_EN     = 32'h0010_0000;
   localparam logic [31:0] M_OUTP_EN   = 32'h0020_0000;
   localparam logic [31:0] M_CON_EN    = 32'h0040_0000;
   localparam logic [31:0] M_R_IN      = 32'h0080_0000;
   localparam logic [31:0] M_GRA       = 32'h0100_0000;
   localparam logic [31:0] M_GRB       = 32'h0200_0000;
   localparam logic [31:0] M_GRC       = 32'h0400_0000;
   localparam logic [31:0] M_INC_PC    = 32'h0800_0000;

   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_NONE = 5'b00000;

   state_t      r_state;
   state_t      w_seq;
   state_t      w_next;
   class_t      w_cls;
   logic [4:0]  w_op;
   logic        w_alu_class;
   logic        w_done;
   logic [31:0] w_ctrl;
   logic [4:0]  w_alu;
   logic        w_run;
   logic        w_unused_ir;

   assign w_op        = IR[31:27];
   assign w_unused_ir = ^IR[26:0];
   assign w_alu_class = (w_cls == C_ALU) || (w_cls == C_IMM) ||
                        (w_cls == C_MULDIV) || (w_cls == C_NEGNOT);

   // Opcode to instruction class; every unassigned opcode behaves as nop.
   always_comb begin
      w_cls = C_NOP;
      case (w_op)
         5'd0:                                          w_cls = C_LDW;
         5'd1:                                          w_cls = C_LDWI;
         5'd2:                                          w_cls = C_STW;
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: w_cls = C_ALU;
         5'd11, 5'd12, 5'd13:                           w_cls = C_IMM;
         5'd14, 5'd15:                                  w_cls = C_MULDIV;
         5'd16, 5'd17:                                  w_cls = C_NEGNOT;
         5'd18:                                         w_cls = C_BR;
         5'd19:                                         w_cls = C_JR;
         5'd20:                                         w_cls = C_JAL;
         5'd21:                                         w_cls = C_IN;
         5'd22:                                         w_cls = C_OUT;
         5'd23:                                         w_cls = C_MFHI;
         5'd24:                                         w_cls = C_MFLO;
         5'd26:                                         w_cls = C_HALT;
         default:                                       w_cls = C_NOP;
      endcase
   end

   // Per-step control word, ALU op and sequential successor; w_done marks the last step.
   always_comb begin
      w_seq  = r_state;
      w_ctrl = 32'd0;
      w_alu  = ALU_NONE;
      w_run  = 1'b1;
      w_done = 1'b0;
      case (r_state)
         S_RST: w_done = 1'b1;
         S_T0: begin
            w_ctrl = M_PC_OUT | M_MAR_EN | M_INC_PC | M_ZLOW_IN;
            w_seq  = S_T1;
         end
         S_T1: begin
            w_ctrl = M_ZLOW_OUT | M_PC_EN | M_MDR_READ | M_MDR_EN;
            w_seq  = S_T2;
         end
         S_T2: begin
            w_ctrl = M_MDR_OUT | M_IR_EN;
            w_seq  = S_T3;
         end
         S_T3: begin
            w_seq = S_T4;
            case (w_cls)
               C_LDW, C_LDWI, C_STW: w_ctrl = M_GRB | M_BA_OUT | M_Y_EN;
               C_ALU, C_IMM:         w_ctrl = M_GRB | M_R_OUT | M_Y_EN;
               C_MULDIV:             w_ctrl = M_GRA | M_R_OUT | M_Y_EN;
               C_NEGNOT:             w_ctrl = M_GRB | M_R_OUT | M_ZLOW_IN;
               C_BR:                 w_ctrl = M_GRA | M_R_OUT | M_CON_EN;
               C_JAL:                w_ctrl = M_PC_OUT | M_GRB | M_R_IN;
               C_JR:   begin w_ctrl = M_GRA | M_R_OUT | M_PC_EN;     w_done = 1'b1; end
               C_IN:   begin w_ctrl = M_INP_OUT | M_GRA | M_R_IN;    w_done = 1'b1; end
               C_OUT:  begin w_ctrl = M_GRA | M_R_OUT | M_OUTP_EN;   w_done = 1'b1; end
               C_MFHI: begin w_ctrl = M_HI_OUT | M_GRA | M_R_IN;     w_done = 1'b1; end
               C_MFLO: begin w_ctrl = M_LO_OUT | M_GRA | M_R_IN;     w_done = 1'b1; end
               C_HALT:               w_seq  = S_HALT;
               default:              w_done = 1'b1;
            endcase
            if (w_alu_class) w_alu = w_op;
            else             w_alu = ALU_NONE;
         end
         S_T4: begin
            w_seq = S_T5;
            case (w_cls)
               C_LDW, C_LDWI, C_STW: begin w_ctrl = M_C_OUT | M_ZLOW_IN; w_alu = ALU_ADD; end
               C_ALU:    begin w_ctrl = M_GRC | M_R_OUT | M_ZLOW_IN; w_alu = w_op; end
               C_IMM:    begin w_ctrl = M_C_OUT | M_ZLOW_IN;         w_alu = w_op; end
               C_MULDIV: begin w_ctrl = M_GRB | M_R_OUT | M_ZLOW_IN | M_ZHIGH_IN; w_alu = w_op; end
               C_NEGNOT: begin w_ctrl = M_ZLOW_OUT | M_GRA | M_R_IN; w_alu = w_op; w_done = 1'b1; end
               C_BR:           w_ctrl = M_PC_OUT | M_Y_EN;
               C_JAL:    begin w_ctrl = M_GRA | M_R_OUT | M_PC_EN; w_done = 1'b1; end
               default:        w_done = 1'b1;
            endcase
         end
         S_T5: begin
            w_seq = S_T6;
            case (w_cls)
               C_LDW, C_STW:  w_ctrl = M_ZLOW_OUT | M_MAR_EN;
               C_LDWI, C_ALU, C_IMM: begin w_ctrl = M_ZLOW_OUT | M_GRA | M_R_IN; w_done = 1'b1; end
               C_MULDIV:      w_ctrl = M_ZLOW_OUT | M_LO_EN;
               C_BR:    begin w_ctrl = M_C_OUT | M_ZLOW_IN; w_alu = ALU_ADD; end
               default:       w_done = 1'b1;
            endcase
         end
         S_T6: begin
            w_seq = S_T7;
            case (w_cls)
               C_LDW:    w_ctrl = M_MDR_READ | M_MDR_EN;
               C_STW:    w_ctrl = M_GRA | M_R_OUT | M_MDR_EN;
               C_MULDIV: begin w_ctrl = M_ZHIGH_OUT | M_HI_EN; w_done = 1'b1; end
               C_BR: begin
                  // The branch commits on the live condition flag, not a latched copy.
                  if (CON_FF) w_ctrl = M_ZLOW_OUT | M_PC_EN;
                  else        w_ctrl = 32'd0;
                  w_done = 1'b1;
               end
               default:  w_done = 1'b1;
            endcase
         end
         S_T7: begin
            w_done = 1'b1;
            case (w_cls)
               C_LDW:   w_ctrl = M_MDR_OUT | M_GRA | M_R_IN;
               C_STW:   w_ctrl = M_RAM_WR;
               default: w_ctrl = 32'd0;
            endcase
         end
         S_HALT: begin
            w_seq = S_HALT;
            w_run = 1'b0;
         end
         default: w_seq = S_RST;
      endcase
   end

   // Stop only takes effect where an instruction boundary would otherwise enter T0.
   assign w_next = w_done ? (Stop ? S_HALT : S_T0) : w_seq;

   // State register with synchronous active-low Clear.
   always_ff @(posedge Clock) begin
      if (!Clear) r_state <= S_RST;
      else        r_state <= w_next;
   end

   assign ctrl   = w_ctrl;
   assign ALU_op = w_alu;
   assign Run    = w_run;
   assign State  = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed literal checks plus a random run
// compared every cycle against a table-driven instruction-step model.
module tb_control_sequencer;

   logic        Clock  = 1'b0;
   logic        Clear  = 1'b0;
   logic        Stop   = 1'b0;
   logic [31:0] IR     = 32'd0;
   logic        CON_FF = 1'b0;
   logic [31:0] ctrl;
   logic [4:0]  ALU_op;
   logic        Run;
   logic [3:0]  State;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .Stop(Stop), .IR(IR), .CON_FF(CON_FF),
      .ctrl(ctrl), .ALU_op(ALU_op), .Run(Run), .State(State)
   );

   always #5 Clock = ~Clock;

   localparam logic [31:0] PCO = 32'd1 << 0,  ZLO = 32'd1 << 1,  ZHO = 32'd1 << 2,  MDO = 32'd1 << 3;
   localparam logic [31:0] HIO = 32'd1 << 4,  LOO = 32'd1 << 5,  INP = 32'd1 << 6,  CO  = 32'd1 << 7;
   localparam logic [31:0] BAO = 32'd1 << 8,  ROUT = 32'd1 << 9, PCE = 32'd1 << 10, IRE = 32'd1 << 11;
   localparam logic [31:0] MAR = 32'd1 << 12, MDE = 32'd1 << 13, MRD = 32'd1 << 14, RAMW = 32'd1 << 15;
   localparam logic [31:0] YE  = 32'd1 << 16, ZLI = 32'd1 << 17, ZHI = 32'd1 << 18, HIE = 32'd1 << 19;
   localparam logic [31:0] LOE = 32'd1 << 20, OPE = 32'd1 << 21, CONE = 32'd1 << 22, RIN = 32'd1 << 23;
   localparam logic [31:0] GRA = 32'd1 << 24, GRB = 32'd1 << 25, GRC = 32'd1 << 26, INC = 32'd1 << 27;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: instruction steps as a table indexed by class and execute step.
   logic [31:0] fetch [3];
   logic [31:0] prog [16][5];
   int          plen [16];
   int          m_mode  = 0;   // 0 reset, 1 running, 2 halted
   int          m_t     = 0;   // cycle index within instruction (0 = T0)
   bit          m_valid = 1'b0;

   function automatic int cls_of(input logic [4:0] op);
      if (op <= 5'd2)  return int'(op);
      if (op <= 5'd10) return 3;
      if (op <= 5'd13) return 4;
      if (op <= 5'd15) return 5;
      if (op <= 5'd17) return 6;
      if (op >= 5'd18 && op <= 5'd24) return int'(op) - 11;
      if (op == 5'd26) return 15;
      return 14;
   endfunction

   initial begin
      for (int c = 0; c < 16; c++) begin
         plen[c] = 1;
         for (int k = 0; k < 5; k++) prog[c][k] = 32'd0;
      end
      fetch[0] = PCO | MAR | INC | ZLI;
      fetch[1] = ZLO | PCE | MRD | MDE;
      fetch[2] = MDO | IRE;
      plen[0] = 5; prog[0][0] = GRB|BAO|YE; prog[0][1] = CO|ZLI; prog[0][2] = ZLO|MAR;
                   prog[0][3] = MRD|MDE;    prog[0][4] = MDO|GRA|RIN;
      plen[1] = 3; prog[1][0] = GRB|BAO|YE; prog[1][1] = CO|ZLI; prog[1][2] = ZLO|GRA|RIN;
      plen[2] = 5; prog[2][0] = GRB|BAO|YE; prog[2][1] = CO|ZLI; prog[2][2] = ZLO|MAR;
                   prog[2][3] = GRA|ROUT|MDE; prog[2][4] = RAMW;
      plen[3] = 3; prog[3][0] = GRB|ROUT|YE; prog[3][1] = GRC|ROUT|ZLI; prog[3][2] = ZLO|GRA|RIN;
      plen[4] = 3; prog[4][0] = GRB|ROUT|YE; prog[4][1] = CO|ZLI;       prog[4][2] = ZLO|GRA|RIN;
      plen[5] = 4; prog[5][0] = GRA|ROUT|YE; prog[5][1] = GRB|ROUT|ZLI|ZHI;
                   prog[5][2] = ZLO|LOE;     prog[5][3] = ZHO|HIE;
      plen[6] = 2; prog[6][0] = GRB|ROUT|ZLI; prog[6][1] = ZLO|GRA|RIN;
      plen[7] = 4; prog[7][0] = GRA|ROUT|CONE; prog[7][1] = PCO|YE; prog[7][2] = CO|ZLI;
                   prog[7][3] = ZLO|PCE;
      prog[8][0]  = GRA|ROUT|PCE;
      plen[9] = 2; prog[9][0] = PCO|GRB|RIN; prog[9][1] = GRA|ROUT|PCE;
      prog[10][0] = INP|GRA|RIN;
      prog[11][0] = GRA|ROUT|OPE;
      prog[12][0] = HIO|GRA|RIN;
      prog[13][0] = LOO|GRA|RIN;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model advance on each rising edge.
   always @(posedge Clock) begin
      int k;
      int c;
      if (!Clear) begin
         m_mode  = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_mode == 0) begin
            if (Stop) m_mode = 2;
            else begin m_mode = 1; m_t = 0; end
         end else if (m_mode == 1) begin
            if (m_t < 3) m_t++;
            else begin
               k = m_t - 3;
               c = cls_of(IR[31:27]);
               if (c == 15 && k == 0) m_mode = 2;
               else if (k + 1 >= plen[c]) begin
                  if (Stop) m_mode = 2;
                  else m_t = 0;
               end else m_t++;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge Clock) begin
      logic [31:0] e_ctrl;
      logic [4:0]  e_alu;
      logic        e_run;
      logic [3:0]  e_st;
      int k;
      int c;
      if (m_valid) begin
         e_ctrl = 32'd0; e_alu = 5'd0; e_run = 1'b1; e_st = 4'd0;
         if (m_mode == 2) begin
            e_run = 1'b0; e_st = 4'hF;
         end else if (m_mode == 1) begin
            e_st = 4'(m_t + 1);
            if (m_t < 3) e_ctrl = fetch[m_t];
            else begin
               k = m_t - 3;
               c = cls_of(IR[31:27]);
               if (k < plen[c]) e_ctrl = prog[c][k];
               if (c == 7 && k == 3 && !CON_FF) e_ctrl = 32'd0;
               if ((e_ctrl & CO) != 32'd0 && (c <= 2 || c == 7)) e_alu = 5'b00011;
               else if (c >= 3 && c <= 6 && k < 2) e_alu = IR[31:27];
            end
         end
         check("cyc_ctrl",  ctrl,          e_ctrl);
         check("cyc_alu",   {27'd0, ALU_op}, {27'd0, e_alu});
         check("cyc_run",   {31'd0, Run},  {31'd0, e_run});
         check("cyc_state", {28'd0, State}, {28'd0, e_st});
      end
   end

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      cycn(2);
      check("rst_state", {28'd0, State}, 32'd0);
      check("rst_ctrl",  ctrl, 32'd0);
      check("rst_run",   {31'd0, Run}, 32'd1);
      check("rst_alu",   {27'd0, ALU_op}, 32'd0);

      // ldw
      IR = 32'h0090_0002; Clear = 1'b1;
      cyc();
      check("ldw_t0_state", {28'd0, State}, 32'd1);
      check("ldw_t0_ctrl",  ctrl, 32'h0802_1001);
      cycn(4);
      check("ldw_t4_ctrl", ctrl, 32'h0002_0080);
      check("ldw_t4_alu",  {27'd0, ALU_op}, 32'd3);
      cycn(3);
      check("ldw_t7_state", {28'd0, State}, 32'd8);
      check("ldw_t7_ctrl",  ctrl, 32'h0180_0008);
      cyc();
      check("ldw_back_t0", {28'd0, State}, 32'd1);

      // add
      IR = {5'b00011, 27'h0123456};
      cycn(4);
      check("add_t4_alu", {27'd0, ALU_op}, 32'd3);
      cyc();
      check("add_t5_ctrl", ctrl, 32'h0180_0002);
      cyc();
      check("add_back_t0", {28'd0, State}, 32'd1);

      // branch, CON_FF low then high within T6
      IR = {5'b10010, 27'h0000abc}; CON_FF = 1'b0;
      cycn(6);
      check("br_t6_state", {28'd0, State}, 32'd7);
      check("br_t6_nocond", ctrl, 32'd0);
      CON_FF = 1'b1; #1;
      check("br_t6_cond", ctrl, 32'h0000_0402);
      CON_FF = 1'b0;
      cyc();
      check("br_back_t0", {28'd0, State}, 32'd1);

      // mul
      IR = {5'b01110, 27'h0000001};
      cycn(4);
      check("mul_t4_ctrl", ctrl, 32'h0206_0200);
      cyc();
      check("mul_t5_ctrl", ctrl, 32'h0010_0002);
      cyc();
      check("mul_t6_ctrl", ctrl, 32'h0008_0004);
      cyc();

      // stw interrupted by Clear in T5
      IR = {5'b00010, 27'h0000010};
      cycn(5);
      check("stw_t5_state", {28'd0, State}, 32'd6);
      Clear = 1'b0;
      cyc();
      check("stw_clear_rst", {28'd0, State}, 32'd0);
      Clear = 1'b1;
      cyc();
      check("stw_rel_t0", {28'd0, State}, 32'd1);

      // Stop raised during T4 of add: honoured only at the boundary
      IR = {5'b00011, 27'h0000777};
      cycn(4);
      Stop = 1'b1;
      cyc();
      check("stop_t5_state", {28'd0, State}, 32'd6);
      cyc();
      check("stop_halt_state", {28'd0, State}, 32'hF);
      check("stop_halt_run",   {31'd0, Run}, 32'd0);
      Stop = 1'b0;
      Clear = 1'b0; cyc();
      Clear = 1'b1; cyc();
      check("stop_rel_t0", {28'd0, State}, 32'd1);

      // halt opcode held for 10 cycles
      IR = {5'b11010, 27'h0};
      cycn(4);
      for (int i = 0; i < 10; i++) begin
         check("halt_state", {28'd0, State}, 32'hF);
         check("halt_run",   {31'd0, Run}, 32'd0);
         check("halt_ctrl",  ctrl, 32'd0);
         cyc();
      end
      Clear = 1'b0; cyc();
      check("halt_clr_state", {28'd0, State}, 32'd0);
      check("halt_clr_run",   {31'd0, Run}, 32'd1);
      Clear = 1'b1; cyc();
      check("halt_rel_t0", {28'd0, State}, 32'd1);

      // Random run; IR changes only at T0 or while not executing
      for (int i = 0; i < 6000; i++) begin
         CON_FF = 1'($urandom_range(1, 0));
         if (m_mode == 2) Clear = ($urandom_range(9, 0) != 0);
         else             Clear = ($urandom_range(59, 0) != 0);
         Stop = (m_mode == 1) && ($urandom_range(7, 0) == 0);
         if (m_mode != 1 || m_t == 0) IR = $urandom();
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
